// File: rtl/blackbox_adder_responder.sv
`default_nettype none
// ============================================================================
// Module   : blackbox_adder_responder
// Summary  : Chunk-serial BW+1-bit adder behind a req/resp valid-ready port.
//            Optional subtract mode when BLACKBOX_ADDER_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module blackbox_adder_responder #(
   parameter int BW    = 32,
   parameter int CHUNK = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          io_req_valid,
   output logic          io_req_ready,
   input  logic [BW-1:0] io_in1,
   input  logic [BW-1:0] io_in2,
`ifdef BLACKBOX_ADDER_SUB_EN
   input  logic          io_req_sub,
`endif
   output logic          io_resp_valid,
   input  logic          io_resp_ready,
   output logic [BW:0]   io_out,
   output logic          io_busy
);

   localparam int c_nchunk = BW / CHUNK;
   localparam int c_iw     = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
   localparam logic [c_iw-1:0] c_last = c_iw'(c_nchunk - 1);

   if ((BW % CHUNK) != 0) begin : g_bad_chunk
      $error("blackbox_adder_responder: BW must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [BW-1:0]     r_in1;
   logic [BW-1:0]     r_in2;
   logic [BW-1:0]     r_acc;
   logic              r_carry;
   logic              r_sub;
   logic [c_iw-1:0]   r_idx;

   logic              w_sub_in;
   logic [CHUNK-1:0]  w_b;
   logic [CHUNK:0]    w_sum;
   logic [BW-1:0]     w_acc_next;
   logic              w_top;

`ifdef BLACKBOX_ADDER_SUB_EN
   assign w_sub_in = io_req_sub;
`else
   assign w_sub_in = 1'b0;
`endif

   // Operands shift right each cycle, so the active chunk is always the low one.
   assign w_b   = r_sub ? ~r_in2[CHUNK-1:0] : r_in2[CHUNK-1:0];
   assign w_sum = {1'b0, r_in1[CHUNK-1:0]} + {1'b0, w_b} + {{CHUNK{1'b0}}, r_carry};

   // In subtract mode the top bit is a borrow, i.e. the inverted final carry.
   assign w_top = r_sub ? ~w_sum[CHUNK] : w_sum[CHUNK];

   // Sum chunks enter at the top of the accumulator; after NCHUNK cycles
   // chunk k has landed in its own bit slice.
   if (c_nchunk == 1) begin : g_single
      assign w_acc_next = w_sum[CHUNK-1:0];
   end else begin : g_multi
      assign w_acc_next = {w_sum[CHUNK-1:0], r_acc[BW-1:CHUNK]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_in1         <= '0;
         r_in2         <= '0;
         r_acc         <= '0;
         r_carry       <= 1'b0;
         r_sub         <= 1'b0;
         r_idx         <= '0;
         io_req_ready  <= 1'b1;
         io_resp_valid <= 1'b0;
         io_out        <= '0;
         io_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (io_req_valid) begin
                  r_in1        <= io_in1;
                  r_in2        <= io_in2;
                  r_sub        <= w_sub_in;
                  r_carry      <= w_sub_in;
                  r_acc        <= '0;
                  r_idx        <= '0;
                  io_req_ready <= 1'b0;
                  io_busy      <= 1'b1;
                  r_state      <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               r_acc   <= w_acc_next;
               r_carry <= w_sum[CHUNK];
               r_in1   <= r_in1 >> CHUNK;
               r_in2   <= r_in2 >> CHUNK;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == c_last) begin
                  r_idx         <= '0;
                  io_resp_valid <= 1'b1;
                  io_out        <= {w_top, w_acc_next};
                  r_state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (io_resp_ready) begin
                  io_resp_valid <= 1'b0;
                  io_out        <= '0;
                  io_req_ready  <= 1'b1;
                  io_busy       <= 1'b0;
                  r_state       <= ST_IDLE;
               end
            end
            default: begin
               io_resp_valid <= 1'b0;
               io_out        <= '0;
               io_req_ready  <= 1'b1;
               io_busy       <= 1'b0;
               r_state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
